// File: rtl/game_pkg.sv
// Shared types and constants for the runner-game controller.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_e;

  localparam int unsigned BCD_W = 4;

endpackage

// File: rtl/game_ctrl_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear and saturation at all-9s.
module bcd_counter
  import game_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    inc_i,
  output logic [BCD_W*DIGITS-1:0] value_o,
  output logic                    sat_o
);

  logic [BCD_W*DIGITS-1:0] value_q, value_d;
  logic                    carry;

  always_comb begin
    value_d = value_q;
    sat_o   = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (value_q[i*BCD_W +: BCD_W] != 4'd9) sat_o = 1'b0;
    end
    // Ripple carry: each digit at 9 rolls to 0 and passes the carry upward.
    carry = inc_i & ~sat_o;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (value_q[i*BCD_W +: BCD_W] == 4'd9) begin
          value_d[i*BCD_W +: BCD_W] = '0;
        end else begin
          value_d[i*BCD_W +: BCD_W] = value_q[i*BCD_W +: BCD_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (clr_i) value_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) value_q <= '0;
    else         value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/game_ctrl.sv
// Game-state controller: frame-synchronous FSM, button event latching,
// BCD score / high score and scroll-speed ramp.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned SCORE_DIGITS     = 4,
  parameter int unsigned FRAMES_PER_POINT = 6,
  parameter int unsigned POINTS_PER_LEVEL = 100,
  parameter int unsigned SPEED_MIN        = 1,
  parameter int unsigned SPEED_MAX        = 15
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      START_N,
  input  logic                      PAUSE_N,
  input  logic                      vs,
  input  logic                      collision,
  output logic [1:0]                state,
  output logic                      game_status,
  output logic [3:0]                speed,
  output logic [4*SCORE_DIGITS-1:0] score,
  output logic [4*SCORE_DIGITS-1:0] hi_score,
  output logic                      frame_tick
);

  localparam int unsigned SW = BCD_W * SCORE_DIGITS;
  localparam int unsigned FW = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
  localparam int unsigned LW = (POINTS_PER_LEVEL > 1) ? $clog2(POINTS_PER_LEVEL) : 1;

  logic          vs_q, start_q, pause_q;
  logic          start_flag_q, pause_flag_q;
  logic          frame_tick_q, game_status_q;
  state_e        state_q;
  logic [3:0]    speed_q;
  logic [SW-1:0] hi_q;
  logic [FW-1:0] frame_cnt_q;
  logic [LW-1:0] level_cnt_q;

  logic          tick, start_fall, pause_fall, start_ev, pause_ev;
  logic          clr_game, run_step, frame_wrap, score_inc, level_step, level_wrap;
  logic [SW-1:0] score_val;
  logic          score_sat;

  always_comb begin
    tick       = vs_q & ~vs;
    start_fall = start_q & ~START_N;
    pause_fall = pause_q & ~PAUSE_N;
    // A press landing on the tick edge itself still counts for this frame.
    start_ev   = start_flag_q | start_fall;
    pause_ev   = pause_flag_q | pause_fall;
    clr_game   = 1'b0;
    run_step   = 1'b0;
    if (tick) begin
      unique case (state_q)
        ST_RUN:           run_step = ~collision & ~pause_ev;
        ST_IDLE, ST_OVER: clr_game = start_ev;
        default:          ;
      endcase
    end
    frame_wrap = run_step && (frame_cnt_q == FW'(FRAMES_PER_POINT - 1));
    score_inc  = frame_wrap;
    level_step = score_inc & ~score_sat;
    level_wrap = level_step && (level_cnt_q == LW'(POINTS_PER_LEVEL - 1));
  end

  bcd_counter #(
    .DIGITS (SCORE_DIGITS)
  ) u_score (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .clr_i   (clr_game),
    .inc_i   (score_inc),
    .value_o (score_val),
    .sat_o   (score_sat)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      vs_q          <= 1'b0;
      start_q       <= 1'b1;
      pause_q       <= 1'b1;
      start_flag_q  <= 1'b0;
      pause_flag_q  <= 1'b0;
      frame_tick_q  <= 1'b0;
      game_status_q <= 1'b0;
      state_q       <= ST_IDLE;
      speed_q       <= 4'(SPEED_MIN);
      hi_q          <= '0;
      frame_cnt_q   <= '0;
      level_cnt_q   <= '0;
    end else begin
      vs_q         <= vs;
      start_q      <= START_N;
      pause_q      <= PAUSE_N;
      frame_tick_q <= tick;
      if (tick) begin
        start_flag_q <= 1'b0;
        pause_flag_q <= 1'b0;
      end else begin
        if (start_fall) start_flag_q <= 1'b1;
        if (pause_fall) pause_flag_q <= 1'b1;
      end

      if (tick) begin
        unique case (state_q)
          ST_RUN: begin
            if (collision) begin
              state_q       <= ST_OVER;
              game_status_q <= 1'b0;
              if (score_val > hi_q) hi_q <= score_val;
            end else if (pause_ev) begin
              state_q       <= ST_PAUSE;
              game_status_q <= 1'b0;
            end
          end
          ST_PAUSE: begin
            if (pause_ev) begin
              state_q       <= ST_RUN;
              game_status_q <= 1'b1;
            end
          end
          ST_IDLE, ST_OVER: begin
            if (start_ev) begin
              state_q       <= ST_RUN;
              game_status_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (clr_game) begin
        frame_cnt_q <= '0;
        level_cnt_q <= '0;
        speed_q     <= 4'(SPEED_MIN);
      end else begin
        if (run_step)   frame_cnt_q <= frame_wrap ? '0 : frame_cnt_q + FW'(1);
        if (level_step) level_cnt_q <= level_wrap ? '0 : level_cnt_q + LW'(1);
        if (level_wrap && (speed_q < 4'(SPEED_MAX))) speed_q <= speed_q + 4'd1;
      end
    end
  end

  assign state       = state_q;
  assign game_status = game_status_q;
  assign speed       = speed_q;
  assign score       = score_val;
  assign hi_score    = hi_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Randomized bench for game_ctrl: two parameterisations driven in lock-step
// against a frame-level reference model.
module tb_game_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START_N = 1'b1;
  logic        PAUSE_N = 1'b1;
  logic        vs = 1'b1;
  logic        collision = 1'b0;

  logic [1:0]  state_m, state_s;
  logic        gs_m, gs_s, ft_m, ft_s;
  logic [3:0]  speed_m, speed_s;
  logic [15:0] score_m, hi_m;
  logic [3:0]  score_s, hi_s;

  int checks = 0;
  int errors = 0;

  // reference model state
  int st = 0;
  int run_frames = 0;
  int hi_main = 0;
  int hi_small = 0;

  always #5 CLK = ~CLK;

  game_ctrl #(
    .SCORE_DIGITS(4), .FRAMES_PER_POINT(6), .POINTS_PER_LEVEL(100),
    .SPEED_MIN(1), .SPEED_MAX(15)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .START_N(START_N), .PAUSE_N(PAUSE_N),
    .vs(vs), .collision(collision), .state(state_m), .game_status(gs_m),
    .speed(speed_m), .score(score_m), .hi_score(hi_m), .frame_tick(ft_m)
  );

  game_ctrl #(
    .SCORE_DIGITS(1), .FRAMES_PER_POINT(1), .POINTS_PER_LEVEL(3),
    .SPEED_MIN(1), .SPEED_MAX(4)
  ) dut_small (
    .CLK(CLK), .RST_N(RST_N), .START_N(START_N), .PAUSE_N(PAUSE_N),
    .vs(vs), .collision(collision), .state(state_s), .game_status(gs_s),
    .speed(speed_s), .score(score_s), .hi_score(hi_s), .frame_tick(ft_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int score_of(input int frames, input int fpp, input int digits);
    int cap = 1;
    for (int i = 0; i < digits; i++) cap = cap * 10;
    return imin(frames / fpp, cap - 1);
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic void model_tick(input bit sev, input bit pev, input bit col);
    case (st)
      1: begin
        if (col) begin
          if (score_of(run_frames, 6, 4) > hi_main)  hi_main  = score_of(run_frames, 6, 4);
          if (score_of(run_frames, 1, 1) > hi_small) hi_small = score_of(run_frames, 1, 1);
          st = 3;
        end else if (pev) st = 2;
        else run_frames++;
      end
      2: if (pev) st = 1;
      default: if (sev) begin st = 1; run_frames = 0; end
    endcase
  endfunction

  task automatic compare_all(input string pfx);
    int sm, ss;
    sm = score_of(run_frames, 6, 4);
    ss = score_of(run_frames, 1, 1);
    check({pfx, "_state"},  32'(state_m), 32'(st));
    check({pfx, "_status"}, 32'(gs_m),    32'(st == 1));
    check({pfx, "_speed"},  32'(speed_m), 32'(imin(1 + sm / 100, 15)));
    check({pfx, "_score"},  32'(score_m), to_bcd(sm));
    check({pfx, "_hi"},     32'(hi_m),    to_bcd(hi_main));
    check({pfx, "_s_state"}, 32'(state_s), 32'(st));
    check({pfx, "_s_speed"}, 32'(speed_s), 32'(imin(1 + ss / 3, 4)));
    check({pfx, "_s_score"}, 32'(score_s), to_bcd(ss));
    check({pfx, "_s_hi"},    32'(hi_s),    to_bcd(hi_small));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press_start();
    START_N = 1'b0; cyc(2); START_N = 1'b1; cyc(2);
  endtask

  task automatic press_pause();
    PAUSE_N = 1'b0; cyc(2); PAUSE_N = 1'b1; cyc(2);
  endtask

  task automatic frame(input int ns, input int np, input bit col);
    bit found = 1'b0;
    vs = 1'b1;
    cyc(2);
    repeat (ns) press_start();
    repeat (np) press_pause();
    @(negedge CLK);
    check("tick_idle", 32'(ft_m | ft_s), 32'd0);
    @(posedge CLK); #1;
    collision = col;
    vs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (ft_m && ft_s) begin found = 1'b1; break; end
    end
    check("tick_seen", 32'(found), 32'd1);
    model_tick(ns > 0, np > 0, col);
    compare_all("frm");
    @(posedge CLK); #1;
    collision = 1'b0;
    @(negedge CLK);
    check("tick_pulse", 32'(ft_m), 32'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    // reset with vs high: no tick may appear until vs falls
    cyc(3);
    @(negedge CLK);
    compare_all("rst");
    check("rst_tick", 32'(ft_m), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("no_tick", 32'(ft_m | ft_s), 32'd0);
    end
    @(posedge CLK); #1;

    frame(0, 1, 0);               // pause ignored in IDLE
    frame(3, 0, 0);               // three presses, one start event
    check("started", 32'(state_m), 32'd1);

    for (int i = 0; i < 600; i++) frame(0, 0, 0);
    check("score600", 32'(score_m), 32'h0100);
    check("speed600", 32'(speed_m), 32'd2);
    check("small_sat", 32'(score_s), 32'd9);
    check("small_spd", 32'(speed_s), 32'd4);

    frame(0, 1, 0);
    for (int i = 0; i < 10; i++) frame((i == 4) ? 2 : 0, 0, 0);
    check("paused_score", 32'(score_m), 32'h0100);
    frame(0, 2, 0);
    check("resumed", 32'(state_m), 32'd1);

    frame(0, 1, 1);               // collision beats pause
    check("over", 32'(state_m), 32'd3);
    check("hi_latch", 32'(hi_m), 32'h0100);
    frame(1, 0, 0);
    check("restart_score", 32'(score_m), 32'h0000);
    check("restart_hi", 32'(hi_m), 32'h0100);

    for (int i = 0; i < 252; i++) frame(0, 0, 0);
    check("score42", 32'(score_m), 32'h0042);

    // reset mid-frame during RUN
    vs = 1'b1;
    cyc(3);
    RST_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    st = 0; run_frames = 0; hi_main = 0; hi_small = 0;
    compare_all("midrst");
    check("midrst_tick", 32'(ft_m), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    cyc(2);

    for (int i = 0; i < 300; i++) begin
      int ns, np;
      bit col;
      ns  = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3)) : 0;
      np  = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 2)) : 0;
      col = ($urandom_range(0, 19) == 0);
      frame(ns, np, col);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
